eth_tx_sched: RTL
=================

Name: eth_tx_sched

Overview:
- Scheduler that shares the single Ethernet TX packet builder between two requesters:
  - video line segments, tagged with the segment index from the TMDS timing block;
  - audio sample packets.
- Sits in the rx0_pclk domain between the timing/line-buffer logic and the TX packet builder.
- Grants one packet at a time, enforces an inter-packet gap, and guards against a hung builder with a timeout.
- Video has priority; audio is protected from starvation by a wait-age threshold.

Parameters:
IFG_CYCLES, 12, idle cycles enforced after each packet before the next grant (min 1)
TIMEOUT, 4096, max cycles in BUSY waiting for tx_done before abort
AUD_MAX_WAIT, 2048, audio wait age at or above which audio beats video
CNT_W, 16, width of wait-age counter and statistics counters

Ports:
rx0_pclk  in  1  pixel clock; all logic posedge
rstbtn_n  in  1  asynchronous active-low reset
vid_req  in  1  level; video segment ready; held until vid_ack
vid_index  in  12  segment index; valid while vid_req high
vid_ack  out  1  one-cycle pulse; video request accepted
aud_req  in  1  level; audio packet ready; held until aud_ack
aud_ack  out  1  one-cycle pulse; audio request accepted
tx_start  out  1  one-cycle pulse to packet builder
tx_sel  out  1  0 = video, 1 = audio; held from tx_start until return to IDLE
tx_index  out  12  latched vid_index for video; 0 for audio
tx_done  in  1  one-cycle pulse from builder; packet finished
busy  out  1  high in every state other than IDLE
timeout_err  out  1  sticky; set on timeout abort; cleared only by reset
vid_pkt_cnt  out  CNT_W  granted video packets (see Optional Feature)
aud_pkt_cnt  out  CNT_W  granted audio packets (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-low. While it is asserted:
  - state = IDLE;
  - every output = 0, including tx_sel, tx_index, timeout_err and both counters;
  - internal counters = 0.
- Reset mid-packet abandons the packet; no ack or tx_start is issued afterwards.
- All outputs are registered.
- States: IDLE, GRANT, BUSY, GAP.
- IDLE:
  - Arbitration is evaluated every cycle.
  - Only vid_req high -> video. Only aud_req high -> audio.
  - Both high -> audio if aud_age >= AUD_MAX_WAIT, else video.
  - On a grant, latch tx_sel and tx_index, then go to GRANT.
- GRANT (exactly 1 cycle):
  - tx_start = 1, plus the matching ack = 1.
  - Timing: request seen in IDLE at cycle N -> ack and tx_start at cycle N+1.
  - Next state is BUSY; the timeout counter is cleared.
- BUSY:
  - tx_done -> GAP.
  - Otherwise the timeout counter increments.
  - Counter reaching TIMEOUT-1 with no tx_done -> set timeout_err, go to GAP.
  - tx_done arriving in the same cycle as the timeout counts as completion; timeout_err is not set.
- GAP: count IFG_CYCLES cycles, then go to IDLE. Requests are ignored while in GAP.
- tx_done outside BUSY is ignored.
- aud_age:
  - increments each cycle aud_req = 1 and the state is not GRANT-with-audio;
  - saturates at all-ones;
  - clears to 0 in the audio GRANT cycle, or whenever aud_req = 0.
- A requester dropping its req before ack simply withdraws; this is not an error.
- vid_index changes while vid_req is high are permitted; the value sampled in the IDLE grant cycle is used.
- Minimum packet period is 2 + IFG_CYCLES + builder latency cycles.

Optional Feature:
- Macro TX_SCHED_STATS_EN.
- Defined:
  - vid_pkt_cnt / aud_pkt_cnt increment in the corresponding GRANT cycle;
  - they wrap modulo 2^CNT_W;
  - reset to 0.
- Undefined: both outputs are tied to 0 and no counter logic is generated.
- Scheduling behaviour is identical either way.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, GRANT=2'd1, BUSY=2'd2, GAP=2'd3;
  - tx_sel codes: SEL_VID=1'b0, SEL_AUD=1'b1.
- One sub-module: eth_tx_sched_pick. It is the combinational priority/age comparator, taking (vid_req, aud_req, aud_age) and producing grant_vid / grant_aud.
- FSM, timers and counters remain in the top.

Test Plan:
- Video only: vid_req=1, vid_index=12'd5 at cycle N.
  -> vid_ack and tx_start at N+1, tx_sel=0, tx_index=5.
  -> tx_done at N+10 -> busy falls at N+11+12.
- Both requesting, aud_age < 2048: video granted first.
  -> After video tx_done + 12-cycle gap, audio is granted (video req dropped).
- Audio starvation: aud_req held while video is re-requested back-to-back.
  -> Once aud_age >= 2048, the next IDLE arbitration grants audio (tx_sel=1, tx_index=0) despite vid_req=1.
- Timeout: grant video, never pulse tx_done.
  -> timeout_err=1 after 4096 BUSY cycles, then 12 GAP cycles, then IDLE.
  -> timeout_err stays 1 through later packets.
- Reset mid-BUSY: assert rstbtn_n low asynchronously.
  -> All outputs 0 immediately; after release, a pending vid_req is granted normally.
- TX_SCHED_STATS_EN defined: 3 video and 2 audio grants -> vid_pkt_cnt=3, aud_pkt_cnt=2. Undefined: both read 0.

Source files
------------

// File: rtl/eth_tx_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : eth_tx_sched_pkg                                             |
// | Description : Shared constants for the Ethernet TX scheduler: FSM state    |
// |               encoding and tx_sel codes.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package eth_tx_sched_pkg;

   // Scheduler FSM state encoding
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] BUSY  = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;

   // tx_sel codes presented to the packet builder
   localparam logic SEL_VID = 1'b0;
   localparam logic SEL_AUD = 1'b1;

endpackage : eth_tx_sched_pkg
`default_nettype wire

// File: rtl/eth_tx_sched_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_tx_sched_pick                                            |
// | Description : Combinational priority / age comparator. Video wins unless   |
// |               audio has waited AUD_MAX_WAIT cycles or more.                |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Ports                                                                      |
// |   vid_req   in   video request level                                       |
// |   aud_req   in   audio request level                                       |
// |   aud_age   in   cycles audio has been waiting (CNT_W bits)                |
// |   grant_vid out  video would win arbitration this cycle                    |
// |   grant_aud out  audio would win arbitration this cycle                    |
// +----------------------------------------------------------------------------+
module eth_tx_sched_pick #(
   parameter int CNT_W        = 16,
   parameter int AUD_MAX_WAIT = 2048
) (
   input  logic             vid_req,
   input  logic             aud_req,
   input  logic [CNT_W-1:0] aud_age,
   output logic             grant_vid,
   output logic             grant_aud
);

   // Compare one bit wider so a threshold equal to 2^CNT_W is representable
   // (audio then never gains priority through age alone).
   localparam logic [CNT_W:0] AGE_THR = (CNT_W+1)'(AUD_MAX_WAIT);

   logic aud_starved;

   assign aud_starved = ({1'b0, aud_age} >= AGE_THR);

   // The two grants are mutually exclusive by construction.
   assign grant_aud = aud_req & (~vid_req | aud_starved);
   assign grant_vid = vid_req & ~grant_aud;

endmodule : eth_tx_sched_pick
`default_nettype wire

// File: rtl/eth_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_tx_sched                                                 |
// | Description : Shares the single Ethernet TX packet builder between video   |
// |               line segments and audio sample packets. Grants one packet at |
// |               a time, enforces an inter-packet gap and aborts a packet if  |
// |               the builder fails to report tx_done within TIMEOUT cycles.   |
// |               Video has priority; audio is protected from starvation by a  |
// |               wait-age threshold.                                          |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Optional    : TX_SCHED_STATS_EN - when defined, vid_pkt_cnt/aud_pkt_cnt    |
// |               count granted packets; otherwise both are tied to 0.         |
// |                                                                            |
// | Ports                                                                      |
// |   rx0_pclk    in   pixel clock, all logic on posedge                       |
// |   rstbtn_n    in   asynchronous active-low reset                           |
// |   vid_req     in   video segment ready (level, held until vid_ack)         |
// |   vid_index   in   12-bit segment index, valid while vid_req               |
// |   vid_ack     out  one-cycle pulse, video request accepted                 |
// |   aud_req     in   audio packet ready (level, held until aud_ack)          |
// |   aud_ack     out  one-cycle pulse, audio request accepted                 |
// |   tx_start    out  one-cycle pulse to the packet builder                   |
// |   tx_sel      out  0 = video, 1 = audio, held until return to IDLE         |
// |   tx_index    out  latched vid_index for video, 0 for audio                |
// |   tx_done     in   one-cycle pulse from builder, packet finished           |
// |   busy        out  high in every state other than IDLE                     |
// |   timeout_err out  sticky timeout flag, cleared only by reset              |
// |   vid_pkt_cnt out  granted video packets (CNT_W bits)                      |
// |   aud_pkt_cnt out  granted audio packets (CNT_W bits)                      |
// +----------------------------------------------------------------------------+
module eth_tx_sched #(
   parameter int IFG_CYCLES   = 12,
   parameter int TIMEOUT      = 4096,
   parameter int AUD_MAX_WAIT = 2048,
   parameter int CNT_W        = 16
) (
   input  logic             rx0_pclk,
   input  logic             rstbtn_n,
   input  logic             vid_req,
   input  logic [11:0]      vid_index,
   output logic             vid_ack,
   input  logic             aud_req,
   output logic             aud_ack,
   output logic             tx_start,
   output logic             tx_sel,
   output logic [11:0]      tx_index,
   input  logic             tx_done,
   output logic             busy,
   output logic             timeout_err,
   output logic [CNT_W-1:0] vid_pkt_cnt,
   output logic [CNT_W-1:0] aud_pkt_cnt
);

   import eth_tx_sched_pkg::*;

   localparam int TMO_W = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;
   localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);
   localparam logic [CNT_W-1:0] AGE_MAX  = {CNT_W{1'b1}};

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [CNT_W-1:0] aud_age;

   logic             grant_vid;
   logic             grant_aud;
   logic             tmo_hit;

   logic             vid_ack_nxt;
   logic             aud_ack_nxt;
   logic             tx_start_nxt;
   logic             tx_sel_nxt;
   logic [11:0]      tx_index_nxt;
   logic             busy_nxt;
   logic             timeout_err_nxt;

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   eth_tx_sched_pick #(
      .CNT_W        (CNT_W),
      .AUD_MAX_WAIT (AUD_MAX_WAIT)
   ) u_pick (
      .vid_req   (vid_req),
      .aud_req   (aud_req),
      .aud_age   (aud_age),
      .grant_vid (grant_vid),
      .grant_aud (grant_aud)
   );

   // A tx_done in the final timeout cycle wins: the packet counts as done.
   assign tmo_hit = (state == BUSY) && !tx_done && (tmo_cnt == TMO_LAST);

   // ------------------------------------------------------------------------
   // FSM: state register (outputs are registered alongside the state)
   // ------------------------------------------------------------------------
   always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         state       <= IDLE;
         vid_ack     <= 1'b0;
         aud_ack     <= 1'b0;
         tx_start    <= 1'b0;
         tx_sel      <= SEL_VID;
         tx_index    <= 12'd0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         vid_ack     <= vid_ack_nxt;
         aud_ack     <= aud_ack_nxt;
         tx_start    <= tx_start_nxt;
         tx_sel      <= tx_sel_nxt;
         tx_index    <= tx_index_nxt;
         busy        <= busy_nxt;
         timeout_err <= timeout_err_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vid || grant_aud) state_nxt = GRANT;
         GRANT:   state_nxt = BUSY;
         BUSY:    if (tx_done || tmo_hit)     state_nxt = GAP;
         GAP:     if (gap_cnt == GAP_LAST)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: output logic. Values computed here are the ones the outputs take
   // in the next state, so a grant decided in IDLE at cycle N shows up as
   // ack/tx_start in the GRANT cycle N+1.
   // ------------------------------------------------------------------------
   always_comb begin
      vid_ack_nxt     = (state == IDLE) && grant_vid;
      aud_ack_nxt     = (state == IDLE) && grant_aud;
      tx_start_nxt    = vid_ack_nxt || aud_ack_nxt;
      busy_nxt        = (state_nxt != IDLE);
      timeout_err_nxt = timeout_err || tmo_hit;
      tx_sel_nxt      = tx_sel;
      tx_index_nxt    = tx_index;
      if (aud_ack_nxt) begin
         tx_sel_nxt   = SEL_AUD;
         tx_index_nxt = 12'd0;
      end else if (vid_ack_nxt) begin
         tx_sel_nxt   = SEL_VID;
         tx_index_nxt = vid_index;
      end else if (state_nxt == IDLE) begin
         // Selection is only meaningful from tx_start until back in IDLE.
         tx_sel_nxt   = SEL_VID;
         tx_index_nxt = 12'd0;
      end
   end

   // ------------------------------------------------------------------------
   // Timers. Both counters sit at zero outside their own state, which also
   // gives the clear-on-GRANT behaviour of the timeout counter.
   // ------------------------------------------------------------------------
   always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         tmo_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         if (state == BUSY && !tx_done && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end else begin
            tmo_cnt <= '0;
         end

         if (state == GAP && gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
         end else begin
            gap_cnt <= '0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Audio wait age: counts while audio is pending, clears on withdrawal or
   // in the audio GRANT cycle, saturates rather than wrapping so a very long
   // wait can never look like a short one.
   // ------------------------------------------------------------------------
   always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         aud_age <= '0;
      end else if (!aud_req || (state == GRANT && tx_sel == SEL_AUD)) begin
         aud_age <= '0;
      end else if (aud_age != AGE_MAX) begin
         aud_age <= aud_age + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Optional packet statistics (wrap modulo 2^CNT_W)
   // ------------------------------------------------------------------------
`ifdef TX_SCHED_STATS_EN
   always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         vid_pkt_cnt <= '0;
         aud_pkt_cnt <= '0;
      end else begin
         if (vid_ack) vid_pkt_cnt <= vid_pkt_cnt + CNT_W'(1);
         if (aud_ack) aud_pkt_cnt <= aud_pkt_cnt + CNT_W'(1);
      end
   end
`else
   assign vid_pkt_cnt = '0;
   assign aud_pkt_cnt = '0;
`endif

endmodule : eth_tx_sched
`default_nettype wire
